// File: rtl/dual_a_d_pre_adder.sv
// Dual A-register input stage with an optional 25-bit D/A pre-adder.
// The pre-adder is built only when DUAL_A_D_PRE_ADDER_PREADD_EN is defined; otherwise out3 carries the A term.
module dual_a_d_pre_adder #(
    parameter int A_INPUT  = 0,
    parameter int AREG     = 2,
    parameter int ACASCREG = 2,
    parameter int DREG     = 1,
    parameter int ADREG    = 1
) (
    input  logic        clk,
    input  logic        RSTA,
    input  logic        RSTD,
    input  logic        RSTAD,
    input  logic        CEA1,
    input  logic        CEA2,
    input  logic        CED,
    input  logic        CEAD,
    input  logic [29:0] A,
    input  logic [29:0] Acin,
    input  logic [24:0] D,
    input  logic        in0,
    input  logic        in1,
    input  logic        in2,
    input  logic        in3,
    output logic [29:0] out1,
    output logic [29:0] out2,
    output logic [24:0] out3
);

    generate
        if (!((AREG == 0 && ACASCREG == 0) ||
              (AREG == 1 && ACASCREG == 1) ||
              (AREG == 2 && (ACASCREG == 1 || ACASCREG == 2)))) begin : g_bad_areg
            $error("dual_a_d_pre_adder: illegal AREG/ACASCREG combination");
        end
        if (A_INPUT < 0 || A_INPUT > 1 || DREG < 0 || DREG > 1 || ADREG < 0 || ADREG > 1) begin : g_bad_cfg
            $error("dual_a_d_pre_adder: A_INPUT, DREG and ADREG must be 0 or 1");
        end
    endgenerate

    logic [29:0] a_in;
    logic [29:0] a1_p1;
    logic [29:0] a2_p2;
    logic [29:0] asel;
    logic [24:0] a_term;

    assign a_in = (A_INPUT == 0) ? A : Acin;

    // A1 stage: only meaningful in the two-deep configuration
    always_ff @(posedge clk or negedge RSTA) begin
        if (!RSTA) begin
            a1_p1 <= '0;
        end else if (CEA1 && AREG == 2) begin
            a1_p1 <= a_in;
        end
    end

    // A2 stage: fed by A1 when two-deep, directly by Ain when one-deep
    always_ff @(posedge clk or negedge RSTA) begin
        if (!RSTA) begin
            a2_p2 <= '0;
        end else if (CEA2) begin
            a2_p2 <= (AREG == 2) ? a1_p1 : a_in;
        end
    end

    assign out2   = (AREG == 0) ? a_in : a2_p2;
    assign out1   = (AREG == 2 && ACASCREG == 1) ? a1_p1 : out2;
    assign asel   = (AREG == 2 && in0) ? a1_p1 : out2;
    assign a_term = in1 ? '0 : asel[24:0];

    logic unused_asel_hi;
    assign unused_asel_hi = &{1'b0, asel[29:25]};

`ifdef DUAL_A_D_PRE_ADDER_PREADD_EN
    logic [24:0] d_p1;
    logic [24:0] d_q;
    logic [24:0] d_term;
    logic [24:0] ad_p1;
    logic [24:0] ad_p2;

    always_ff @(posedge clk or negedge RSTD) begin
        if (!RSTD) begin
            d_p1 <= '0;
        end else if (CED) begin
            d_p1 <= D;
        end
    end

    assign d_q    = (DREG == 1) ? d_p1 : D;
    assign d_term = in2 ? d_q : '0;
    // Plain 25-bit add/subtract; the carry out is deliberately dropped
    assign ad_p1  = in3 ? (d_term - a_term) : (d_term + a_term);

    always_ff @(posedge clk or negedge RSTAD) begin
        if (!RSTAD) begin
            ad_p2 <= '0;
        end else if (CEAD) begin
            ad_p2 <= ad_p1;
        end
    end

    assign out3 = (ADREG == 1) ? ad_p2 : ad_p1;
`else
    assign out3 = a_term;

    logic unused_preadd;
    assign unused_preadd = &{1'b0, D, CED, CEAD, RSTD, RSTAD, in2, in3};
`endif

endmodule

// File: tb/tb_dual_a_d_pre_adder.sv
// Randomized and directed bench for dual_a_d_pre_adder (default parameters) with a behavioural model.
module tb_dual_a_d_pre_adder;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        RSTA = 1'b1, RSTD = 1'b1, RSTAD = 1'b1;
    logic        CEA1 = 1'b0, CEA2 = 1'b0, CED = 1'b0, CEAD = 1'b0;
    logic [29:0] A = '0, Acin = '0;
    logic [24:0] D = '0;
    logic        in0 = 1'b0, in1 = 1'b0, in2 = 1'b0, in3 = 1'b0;
    logic [29:0] out1, out2;
    logic [24:0] out3;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural state: the two A pipeline stages, the D register and the AD register
    logic [29:0] m_a1 = '0, m_a2 = '0;
    logic [24:0] m_d = '0, m_ad = '0;

    dual_a_d_pre_adder dut (
        .clk(clk), .RSTA(RSTA), .RSTD(RSTD), .RSTAD(RSTAD),
        .CEA1(CEA1), .CEA2(CEA2), .CED(CED), .CEAD(CEAD),
        .A(A), .Acin(Acin), .D(D),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out1(out1), .out2(out2), .out3(out3)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [24:0] exp_a_term();
        logic [29:0] sel;
        sel = in0 ? m_a1 : m_a2;
        return in1 ? 25'd0 : sel[24:0];
    endfunction

    function automatic logic [24:0] exp_ad();
        longint dt, at, r;
        dt = in2 ? longint'(m_d) : 0;
        at = longint'(exp_a_term());
        r  = in3 ? (dt - at + (longint'(1) << 25)) : (dt + at);
        return 25'(r % (longint'(1) << 25));
    endfunction

    function automatic logic [24:0] exp_out3();
`ifdef DUAL_A_D_PRE_ADDER_PREADD_EN
        return m_ad;
`else
        return exp_a_term();
`endif
    endfunction

    task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/out2"}, out2, m_a2);
        chk({tag, "/out1"}, out1, m_a2);
        chk({tag, "/out3"}, {5'd0, out3}, {5'd0, exp_out3()});
    endtask

    // Async resets take effect in the model at the moment they are driven low
    task automatic set_resets(input logic ra, input logic rd, input logic rad);
        RSTA = ra; RSTD = rd; RSTAD = rad;
        if (!ra)  begin m_a1 = '0; m_a2 = '0; end
        if (!rd)  m_d = '0;
        if (!rad) m_ad = '0;
    endtask

    task automatic tick();
        logic [29:0] n_a1, n_a2;
        logic [24:0] n_d, n_ad;
        @(posedge clk);
        n_a1 = !RSTA  ? '0 : (CEA1 ? A : m_a1);
        n_a2 = !RSTA  ? '0 : (CEA2 ? m_a1 : m_a2);
        n_d  = !RSTD  ? '0 : (CED ? D : m_d);
        n_ad = !RSTAD ? '0 : (CEAD ? exp_ad() : m_ad);
        m_a1 = n_a1; m_a2 = n_a2; m_d = n_d; m_ad = n_ad;
        #1;
    endtask

    initial begin
        // All resets low with A=1 and enables high: everything stays zero
        #2;
        A = 30'd1; D = 25'd7; CEA1 = 1; CEA2 = 1; CED = 1; CEAD = 1; in2 = 1;
        set_resets(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out1", out1, 30'd0);
            chk("rst_out2", out2, 30'd0);
            chk("rst_out3", {5'd0, out3}, 30'd0);
        end

        // Single-cycle A sample propagates through both stages
        set_resets(1'b1, 1'b1, 1'b1);
        D = '0; in2 = 0;
        A = 30'h12345678;
        tick();
        check_all("a_stage1");
        A = 30'd0;
        tick();
        chk("two_stage_out2", out2, 30'h12345678);
        chk("two_stage_out1", out1, 30'h12345678);
        check_all("a_stage2");

        // Enables low: A path holds while A toggles
        CEA1 = 0; CEA2 = 0;
        for (int i = 0; i < 4; i++) begin
            A = $urandom;
            tick();
            chk("hold_out2", out2, 30'h12345678);
        end

        // Pre-add D + A: A2 low bits = 5, D = 0x10
        CEA1 = 1; CEA2 = 1; A = 30'd5;
        D = 25'h10; in0 = 0; in1 = 0; in2 = 1; in3 = 0;
        for (int i = 0; i < 3; i++) tick();
`ifdef DUAL_A_D_PRE_ADDER_PREADD_EN
        chk("preadd_sum", {5'd0, out3}, 30'h15);
`else
        chk("a_term_only", {5'd0, out3}, 30'h5);
`endif
        check_all("preadd");

        // Subtract with wrap: D = 0, A term = 1
        A = 30'd1; D = 25'd0; in3 = 1;
        for (int i = 0; i < 3; i++) tick();
`ifdef DUAL_A_D_PRE_ADDER_PREADD_EN
        chk("sub_wrap", {5'd0, out3}, 30'h1FFFFFF);
`else
        chk("a_term_one", {5'd0, out3}, 30'h1);
`endif
        in1 = 1; in2 = 0;
        tick();
        chk("zero_terms", {5'd0, out3}, 30'd0);
        check_all("zero_terms");

        // Randomized traffic, including occasional independent async resets
        for (int i = 0; i < 300; i++) begin
            A = $urandom; Acin = $urandom; D = 25'($urandom);
            CEA1 = 1'($urandom); CEA2 = 1'($urandom);
            CED = 1'($urandom); CEAD = 1'($urandom);
            in0 = 1'($urandom); in1 = ($urandom_range(0, 3) == 0);
            in2 = 1'($urandom); in3 = 1'($urandom);
            set_resets($urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
                       $urandom_range(0, 15) != 0);
            tick();
            check_all("rand");
        end

        // Async RSTA with the clock stopped
        set_resets(1'b1, 1'b1, 1'b1);
        CEA1 = 1; CEA2 = 1; A = 30'h2AAAAAAA; in0 = 0; in1 = 0;
        tick();
        tick();
        chk("pre_async_out2", out2, 30'h2AAAAAAA);
        clk_en = 0;
        #3;
        set_resets(1'b0, 1'b1, 1'b1);
        #1;
        chk("async_out2", out2, 30'd0);
        chk("async_out1", out1, 30'd0);
        check_all("async");
        set_resets(1'b1, 1'b1, 1'b1);
        clk_en = 1;
        tick();
        check_all("after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_a_d_pre_adder.md
DUAL_A_D_PRE_ADDER -- requirements
Module: dual_a_d_pre_adder

Interface
REQ-001 The block SHALL have parameter A_INPUT, default 0: A-path source, 0 = A port, 1 = Acin cascade port.
REQ-002 The block SHALL have parameter AREG, default 2: A pipeline depth, legal values 0, 1 or 2.
REQ-003 The block SHALL have parameter ACASCREG, default 2: out1 depth; legal only as AREG=0 with 0, AREG=1 with 1, AREG=2 with 1 or 2; illegal combinations SHALL fail elaboration.
REQ-004 The block SHALL have parameter DREG, default 1: D register present (1) or bypassed (0).
REQ-005 The block SHALL have parameter ADREG, default 1: pre-adder output register present (1) or bypassed (0).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low; every reset port below follows this polarity and synchronicity.
REQ-007 Ports SHALL be:
- clk  in  1  sole clock, rising edge
- RSTA  in  1  async active-low reset of A1 and A2
- RSTD  in  1  async active-low reset of D register
- RSTAD  in  1  async active-low reset of AD register
- CEA1  in  1  A1 clock enable
- CEA2  in  1  A2 clock enable
- CED  in  1  D clock enable
- CEAD  in  1  AD clock enable
- A  in  30  direct A operand
- Acin  in  30  cascaded A operand
- D  in  25  pre-adder D operand
- in0  in  1  multiplier-A select: 1 = A1, 0 = A2 stage
- in1  in  1  zero the A term
- in2  in  1  enable the D term
- in3  in  1  subtract: 1 = D - A, 0 = D + A
- out1  out  30  A cascade out (ACOUT)
- out2  out  30  A path to X mux
- out3  out  25  multiplier A operand

Function
REQ-008 Ain SHALL be A when A_INPUT=0, else Acin.
REQ-009 AREG=2: on clk rise, A1<=Ain if CEA1; A2<=A1 if CEA2; out2=A2.
REQ-010 AREG=1: A1 unused; A2<=Ain if CEA2; out2=A2. AREG=0: out2=Ain combinationally.
REQ-011 out1 SHALL equal A1 when AREG=2 and ACASCREG=1, otherwise out2.
REQ-012 Asel SHALL be A1 when AREG=2 and in0=1, otherwise out2; in0 is ignored when AREG<2.
REQ-013 The A term SHALL be 0 when in1=1, otherwise Asel[24:0].
REQ-014 Dq SHALL be the D register, loaded from D when CED, if DREG=1, otherwise D; the D term SHALL be Dq when in2=1, otherwise 0.
REQ-015 AD SHALL be (D term - A term) when in3=1, else (D term + A term), truncated modulo 2^25 with no carry, overflow or saturation output.
REQ-016 out3 SHALL be the AD register, loaded from AD when CEAD, if ADREG=1, otherwise AD combinationally.
REQ-017 in0..in3 SHALL be unregistered and act combinationally on the current cycle.
REQ-018 Latency: out2 SHALL lag Ain by AREG enabled cycles; out3 SHALL lag by one further cycle when ADREG=1.
REQ-019 A register whose CE is low SHALL hold its value; a CE high while the register's reset is asserted SHALL have no effect.

Reset
REQ-020 While RSTA is low, A1 and A2 SHALL be 0 immediately, without waiting for clk.
REQ-021 While RSTD is low, the D register SHALL be 0; while RSTAD is low, the AD register SHALL be 0.
REQ-022 Resets SHALL be independent, e.g. RSTA low leaves the D and AD registers untouched.
REQ-023 With all registers present and reset, out1, out2 and out3 SHALL all be 0.

Configuration
REQ-024 Macro DUAL_A_D_PRE_ADDER_PREADD_EN defined: the D register and pre-adder SHALL be built as in REQ-014 to REQ-016.
REQ-025 Macro not defined: out3 SHALL equal the A term combinationally; D, CED, CEAD, RSTD, RSTAD, in2, in3, DREG and ADREG SHALL be ignored; the ports SHALL remain.

Verification
REQ-026 Reset: hold all resets low, A=1 -> out1=out2=out3=0 across clock edges.
REQ-027 Two-stage A, defaults, CEA1=CEA2=1, A=0x12345678 on a single cycle -> out2=0x12345678 after 2 rising edges; out1 matches out2.
REQ-028 Hold: CEA1=CEA2=0 -> out2 unchanged while A toggles.
REQ-029 Pre-add, in2=1, in3=0, in1=0, D=0x0000010, A2[24:0]=0x0000005 -> out3=0x0000015 one edge after AD is loaded.
REQ-030 Subtract and wrap, in3=1, D=0, A term=1 -> out3=0x1FFFFFF; in1=1, in2=0 -> out3=0.
REQ-031 Async reset: drop RSTA mid-cycle with clk not toggling -> out2 goes to 0 immediately.
